// File: rtl/sirv_tl_fragmenter_a.sv
// TileLink A-channel fragmenter: splits multi-beat Get/Put requests into 32-bit single-beat
// fragments, asking the upstream repeater to replay Gets until the last fragment.
module sirv_tl_fragmenter_a #(
    parameter int unsigned MAX_LGSIZE = 6
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_repeat,
    output logic        io_in_ready,
    input  logic        io_in_valid,
    input  logic [2:0]  io_in_bits_opcode,
    input  logic [2:0]  io_in_bits_param,
    input  logic [2:0]  io_in_bits_size,
    input  logic [1:0]  io_in_bits_source,
    input  logic [29:0] io_in_bits_address,
    input  logic [3:0]  io_in_bits_mask,
    input  logic [31:0] io_in_bits_data,
    input  logic        io_out_ready,
    output logic        io_out_valid,
    output logic [2:0]  io_out_bits_opcode,
    output logic [2:0]  io_out_bits_param,
    output logic [2:0]  io_out_bits_size,
    output logic [1:0]  io_out_bits_source,
    output logic [29:0] io_out_bits_address,
    output logic [3:0]  io_out_bits_mask,
    output logic [31:0] io_out_bits_data,
    output logic        io_out_last,
    output logic        io_busy
);

    localparam int unsigned FragW = MAX_LGSIZE - 2;
    localparam logic [2:0] MaxLg = 3'(MAX_LGSIZE);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    logic [FragW-1:0] frag_q, frag_d;
    logic             fire;
    logic             is_get;
    logic             fragmentable;
    logic [2:0]       lg;
    logic [FragW:0]   total_onehot;
    logic [FragW-1:0] last_idx;

    assign io_out_valid = io_in_valid;
    assign io_in_ready  = io_out_ready;
    assign fire         = io_out_valid & io_out_ready;

    assign is_get       = (io_in_bits_opcode == OpGet);
    assign fragmentable = (is_get || io_in_bits_opcode == OpPutFull ||
                           io_in_bits_opcode == OpPutPartial) && (io_in_bits_size > 3'd2);

    // Oversized requests are clamped, so the counter simply wraps at MAX_LGSIZE bytes.
    assign lg           = (io_in_bits_size > MaxLg) ? MaxLg : io_in_bits_size;
    assign total_onehot = (FragW + 1)'(1) << (lg - 3'd2);
    // When total fills the whole counter the low bits are zero and the decrement yields all-ones.
    assign last_idx     = total_onehot[FragW-1:0] - FragW'(1);

    always_comb begin
        io_out_bits_opcode  = io_in_bits_opcode;
        io_out_bits_param   = io_in_bits_param;
        io_out_bits_source  = io_in_bits_source;
        io_out_bits_data    = io_in_bits_data;
        io_out_bits_size    = io_in_bits_size;
        io_out_bits_address = io_in_bits_address;
        io_out_bits_mask    = io_in_bits_mask;
        io_out_last         = 1'b1;
        io_repeat           = 1'b0;
        if (fragmentable) begin
            io_out_bits_size    = 3'd2;
            // OR is safe: TL guarantees the base is aligned to the full request size.
            io_out_bits_address = io_in_bits_address | (30'(frag_q) << 2);
            io_out_bits_mask    = is_get ? 4'hF : io_in_bits_mask;
            io_out_last         = (frag_q == last_idx);
            io_repeat           = is_get & ~io_out_last;
        end
    end

    always_comb begin
        frag_d = frag_q;
        if (fire) begin
            frag_d = io_out_last ? '0 : frag_q + FragW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frag_q <= '0;
        end else begin
            frag_q <= frag_d;
        end
    end

    assign io_busy = (frag_q != '0);

endmodule

// File: doc/sirv_tl_fragmenter_a.md
# sirv_tl_fragmenter_a

Downstream consumer of the A-channel repeater in the peripheral-bus fragmenter path. Splits TileLink A-channel requests larger than one 32-bit beat into single-beat (size 2) fragments with incrementing addresses. For Get it drives `io_repeat` back to the repeater so the request is replayed once per fragment. Puts pass through beat by beat, with size and address rewritten per beat. Zero-latency, purely forwarding datapath plus a fragment counter.

## Interface
- `MAX_LGSIZE`, default 6: log2 of the largest request size in bytes. Fragment counter width is `MAX_LGSIZE-2`.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `io_repeat`  out  1  to repeater: hold and replay the current request.
- `io_in_ready`  out  1  A-channel ready toward the repeater's deq.
- `io_in_valid`  in  1  A-channel valid from the repeater's deq.
- `io_in_bits_opcode`  in  3  TL opcode: 0 PutFull, 1 PutPartial, 4 Get.
- `io_in_bits_param`  in  3  passed through.
- `io_in_bits_size`  in  3  log2 bytes of the whole request.
- `io_in_bits_source`  in  2  passed through.
- `io_in_bits_address`  in  30  base address, aligned to the request size.
- `io_in_bits_mask`  in  4  byte mask.
- `io_in_bits_data`  in  32  beat data.
- `io_out_ready`  in  1  downstream ready.
- `io_out_valid`  out  1  downstream valid.
- `io_out_bits_opcode`, `io_out_bits_param`, `io_out_bits_source`, `io_out_bits_data`  out  3/3/2/32  passed through.
- `io_out_bits_size`  out  3  fragment size.
- `io_out_bits_address`  out  30  fragment address.
- `io_out_bits_mask`  out  4  fragment mask.
- `io_out_last`  out  1  current fragment is the last of the original request.
- `io_busy`  out  1  a multi-fragment request is in progress (`frag != 0`).

## Operation
- Handshake is combinational pass-through:
  - `io_out_valid = io_in_valid`.
  - `io_in_ready = io_out_ready`.
  - `fire = io_out_valid & io_out_ready`.
- Fragmentable request: opcode in {0, 1, 4} and size > 2.
  - `lg = min(size, MAX_LGSIZE)`.
  - `total = 1 << (lg-2)`.
- Non-fragmentable request (size ≤ 2, or any other opcode):
  - Forwarded unchanged, with `total = 1`.
  - `io_out_last = 1`, `io_repeat = 0`.
- Register `frag`, width `MAX_LGSIZE-2`: index of the current fragment.
- Output fields:
  - Address: `io_out_bits_address = io_in_bits_address | (frag << 2)`. This is an OR, valid because TL requires the base to be size-aligned.
  - Size: `io_out_bits_size = 2` when fragmentable, otherwise the input size.
  - Mask, Get fragment: `4'hF`.
  - Mask, Put or non-fragmentable: the input mask.
- Control outputs:
  - `io_out_last = (frag == total-1)`.
  - `io_repeat = (opcode == 4) & fragmentable & ~io_out_last`.
  - `io_repeat` is combinational and is used by the repeater in the same cycle as `fire`.
- Counter update on `fire`: if `io_out_last`, `frag <= 0`; else `frag <= frag + 1`. No change without `fire`.
- Puts: the upstream delivers `total` beats, each with the base address. Only `frag` distinguishes them.
- Holding the request stable across fragments is the repeater's job. This block does not latch request fields.

## Timing
- Latency 0: the output is combinational from the input and `frag`. No bubble between fragments; one fragment per cycle while `io_out_ready = 1`.
- A `total = N` request takes exactly N `fire` cycles.
- Reset, applied synchronously at the next clock edge:
  - `frag <= 0`.
  - Resulting outputs: `io_busy = 0`; `io_repeat = 0` unless a new multi-fragment Get is presented; `io_out_last = 1` for a single-fragment input.
- Reset mid-burst: the counter drops to 0. The next fragment presented is treated as fragment 0. No recovery of the aborted request.
- Backpressure (`io_out_ready = 0`): `frag` holds and all outputs stay stable while the input is stable. `io_repeat` stays asserted for a pending non-last Get fragment.
- Size larger than `MAX_LGSIZE`: clamped to `MAX_LGSIZE`, so counting wraps at `MAX_LGSIZE` bytes. Illegal input; no error flag.
- `io_in_valid` low mid-burst: `frag` holds; resumes on the next `fire`.

## Test plan
- Get, size 2, address `0x100`, ready held 1 → one fire: out size 2, address `0x100`, `last = 1`, `repeat = 0`, `busy` stays 0.
- Get, size 4, address `0x100`, repeater attached → 4 consecutive fires:
  - Addresses `0x100`, `0x104`, `0x108`, `0x10C`; mask `F` on each.
  - `repeat` = 1, 1, 1, 0; `last` = 0, 0, 0, 1.
  - `busy` goes 0 → 1 → 1 → 1 → 0.
- PutFull, size 4, 4 beats with data `A0..A3`, base `0x200` → out addresses `0x200`…`0x20C` with matching data, size 2, `repeat = 0` throughout, `last` only on beat 3.
- 16-byte Get with `io_out_ready` toggling 1, 0, 0, 1, 1, 1 → exactly 4 fires; `frag` and the address are frozen during the stall; `repeat` stays high until the fourth fragment is pending.
- Get, size 0, address `0x103`, mask `4'b1000` → passed through unchanged: size 0, address `0x103`, mask `1000`, `last = 1`.
- `reset` asserted after the 2nd fire of a 16-byte Get → next cycle `busy = 0`. A fresh 8-byte Get at `0x300` then yields `0x300` and `0x304` with `last` on the second.
